// File: rtl/bcm_sequencer.sv
// Binary-code-modulation LED sequencer: double-buffered brightness words, LSB-first bit planes.
// Optional dead time after each plane when BCM_BLANK_EN is defined.
module bcm_sequencer #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned BITS       = 8,
    parameter int unsigned BASE_TICKS = 1,
    parameter int unsigned BLANK      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [CHANNELS*BITS-1:0] load_data,
    output logic [CHANNELS-1:0]      led,
    output logic [$clog2(BITS)-1:0]  plane,
    output logic                     frame_start,
    output logic                     busy
);

    localparam int unsigned PW = $clog2(BITS);
    localparam int unsigned TW = $clog2(BASE_TICKS << (BITS - 1)) + 1;
    localparam int unsigned W  = CHANNELS * BITS;

    typedef enum logic [1:0] {StIdle, StShow, StBlank} state_t;

    state_t          state_q;
    logic [W-1:0]    shadow_q;
    logic [W-1:0]    active_q;
    logic            pending_q;
    logic [TW-1:0]   tick_q;

    logic            accept;
    logic            seg_end;
    logic            advance;
    logic            boundary;
    logic            start;
    logic            last_plane;
    logic [W-1:0]    next_active;

    // Tick reload value: SHOW for plane p lasts BASE_TICKS << p cycles.
    function automatic logic [TW-1:0] show_len(input logic [PW-1:0] p);
        return TW'((BASE_TICKS << p) - 1);
    endfunction

    function automatic logic [CHANNELS-1:0] plane_bits(input logic [W-1:0] w,
                                                       input logic [PW-1:0] p);
        logic [BITS-1:0] word;
        logic [CHANNELS-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            word = w[c*BITS +: BITS];
            r[c] = word[p];
        end
        return r;
    endfunction

    assign load_ready = ~pending_q;

    always_comb begin
        accept      = load_valid && !pending_q;
        seg_end     = (tick_q == '0);
        last_plane  = (plane == PW'(BITS - 1));
`ifdef BCM_BLANK_EN
        advance     = (state_q == StBlank) && seg_end;
`else
        advance     = (state_q == StShow) && seg_end;
`endif
        boundary    = (state_q == StIdle) || (advance && last_plane);
        start       = boundary && en;
        // A word pending at a starting boundary is shown from plane 0 of the new frame.
        next_active = (start && pending_q) ? shadow_q : active_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            tick_q      <= '0;
            led         <= '0;
            plane       <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (accept) begin
                shadow_q  <= load_data;
                pending_q <= 1'b1;
            end

            if (start) begin
                state_q     <= StShow;
                plane       <= '0;
                tick_q      <= show_len('0);
                led         <= plane_bits(next_active, '0);
                frame_start <= 1'b1;
                busy        <= 1'b1;
                if (pending_q) begin
                    active_q  <= shadow_q;
                    pending_q <= 1'b0;
                end
            end else if (boundary && state_q != StIdle) begin
                state_q <= StIdle;
                plane   <= '0;
                led     <= '0;
                busy    <= 1'b0;
            end else if (advance) begin
                state_q <= StShow;
                plane   <= plane + 1'b1;
                tick_q  <= show_len(plane + 1'b1);
                led     <= plane_bits(active_q, plane + 1'b1);
`ifdef BCM_BLANK_EN
            end else if (state_q == StShow && seg_end) begin
                state_q <= StBlank;
                tick_q  <= TW'(BLANK - 1);
                led     <= '0;
`endif
            end else if (state_q != StIdle) begin
                tick_q <= tick_q - 1'b1;
            end
        end
    end

`ifndef BCM_BLANK_EN
    logic unused_blank;
    assign unused_blank = (BLANK != 0);
`endif

endmodule
